// File: rtl/rename_map_table_if.sv
// Rename-port bundle between decode (master) and the alias table (slave).
// Per-port flattened fields: rn_valid/rn_dst/rn_new_tag/src_a/src_b in, tag_a/tag_b/old_tag/old_valid back.
interface rename_map_table_if #(
  parameter int AW    = 5,
  parameter int TAG_W = 6,
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0]       rn_valid;
  logic [WIDTH*AW-1:0]    rn_dst;
  logic [WIDTH*TAG_W-1:0] rn_new_tag;
  logic [WIDTH*AW-1:0]    src_a;
  logic [WIDTH*AW-1:0]    src_b;
  logic [WIDTH*TAG_W-1:0] tag_a;
  logic [WIDTH*TAG_W-1:0] tag_b;
  logic [WIDTH*TAG_W-1:0] old_tag;
  logic [WIDTH-1:0]       old_valid;

  modport master (
    output rn_valid, rn_dst, rn_new_tag, src_a, src_b,
    input  tag_a, tag_b, old_tag, old_valid
  );

  modport slave (
    input  rn_valid, rn_dst, rn_new_tag, src_a, src_b,
    output tag_a, tag_b, old_tag, old_valid
  );
endinterface

// File: rtl/rename_map_table.sv
// Register alias table: WIDTH renames/cycle, intra-group bypass, flush from retirement map.
// Ports: clk, reset (sync high), stall, rn (rename bundle), ckpt_req/grant/id/free_mask/avail,
// restore/restore_id, flush/commit_map. Checkpoints exist only when RMT_CKPT_EN is defined.
module rename_map_table #(
  parameter int NUM_ARCH = 32,
  parameter int TAG_W    = 6,
  parameter int WIDTH    = 2,
  parameter int NCKPT    = 4,
  localparam int AW      = $clog2(NUM_ARCH),
  localparam int CW      = (NCKPT > 1) ? $clog2(NCKPT) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  rename_map_table_if.slave         rn,
  input  logic                      ckpt_req,
  output logic                      ckpt_grant,
  output logic [CW-1:0]             ckpt_id,
  input  logic [NCKPT-1:0]          ckpt_free_mask,
  input  logic                      restore,
  input  logic [CW-1:0]             restore_id,
  input  logic                      flush,
  input  logic [NUM_ARCH*TAG_W-1:0] commit_map,
  output logic [CW:0]               ckpt_avail
);

  logic [NUM_ARCH-1:0][TAG_W-1:0] map_q;
  logic [NUM_ARCH-1:0][TAG_W-1:0] map_rn;
  logic [NUM_ARCH-1:0][TAG_W-1:0] restore_map;
  logic [WIDTH-1:0][AW-1:0]       dst;
  logic [WIDTH-1:0][AW-1:0]       sa;
  logic [WIDTH-1:0][AW-1:0]       sb;
  logic [WIDTH-1:0][TAG_W-1:0]    nt;
  logic [WIDTH-1:0][TAG_W-1:0]    ta;
  logic [WIDTH-1:0][TAG_W-1:0]    tb;
  logic [WIDTH-1:0][TAG_W-1:0]    ot;
  logic [WIDTH-1:0][TAG_W-1:0]    old_tag_q;
  logic [WIDTH-1:0]               old_valid_q;
  logic [WIDTH-1:0]               eff;
  logic                           rs_act;
  logic                           rs_hit;
  logic                           do_rn;

  assign dst = rn.rn_dst;
  assign sa  = rn.src_a;
  assign sb  = rn.src_b;
  assign nt  = rn.rn_new_tag;

  // Writes to arch reg 0 are discarded, so r0 is never bypassed either.
  always_comb begin
    eff = '0;
    for (int i = 0; i < WIDTH; i++)
      eff[i] = rn.rn_valid[i] & (dst[i] != '0);
  end

  // Older ports are scanned in ascending order so the youngest
  // older writer of a register is the one that sticks.
  always_comb begin
    map_rn = map_q;
    ta = '0;
    tb = '0;
    ot = '0;
    for (int j = 0; j < WIDTH; j++) begin
      ta[j] = map_q[sa[j]];
      tb[j] = map_q[sb[j]];
      ot[j] = map_q[dst[j]];
      for (int i = 0; i < j; i++) begin
        if (eff[i] && dst[i] == sa[j])  ta[j] = nt[i];
        if (eff[i] && dst[i] == sb[j])  tb[j] = nt[i];
        if (eff[i] && dst[i] == dst[j]) ot[j] = nt[i];
      end
    end
    for (int i = 0; i < WIDTH; i++)
      if (eff[i]) map_rn[dst[i]] = nt[i];
  end

  assign do_rn = ~stall & ~flush & ~rs_act;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_ARCH; r++)
        map_q[r] <= TAG_W'(r);
      old_tag_q   <= '0;
      old_valid_q <= '0;
    end else begin
      old_valid_q <= do_rn ? eff : '0;
      for (int i = 0; i < WIDTH; i++)
        if (do_rn && eff[i]) old_tag_q[i] <= ot[i];
      if (flush)       map_q <= commit_map;
      else if (rs_hit) map_q <= restore_map;
      else if (do_rn)  map_q <= map_rn;
    end
  end

  assign rn.tag_a     = ta;
  assign rn.tag_b     = tb;
  assign rn.old_tag   = old_tag_q;
  assign rn.old_valid = old_valid_q;

`ifdef RMT_CKPT_EN
  logic [NCKPT-1:0][NUM_ARCH-1:0][TAG_W-1:0] snap_q;
  logic [NCKPT-1:0] busy_q;
  logic [NCKPT-1:0] busy_n;
  logic [CW:0]      avail_q;
  logic [CW:0]      avail_n;
  logic [CW-1:0]    free_id;
  logic             any_free;
  logic             grant;

  always_comb begin
    free_id  = '0;
    any_free = 1'b0;
    for (int i = NCKPT - 1; i >= 0; i--)
      if (!busy_q[i]) begin
        free_id  = CW'(i);
        any_free = 1'b1;
      end
  end

  assign grant = ckpt_req & ~stall & any_free & ~flush & ~restore;

  // Grant is applied after the release mask so a same-slot release loses.
  always_comb begin
    busy_n = busy_q & ~ckpt_free_mask;
    if (restore) busy_n[restore_id] = 1'b0;
    if (grant)   busy_n[free_id] = 1'b1;
    if (flush)   busy_n = '0;
    avail_n = '0;
    for (int i = 0; i < NCKPT; i++)
      avail_n = avail_n + (CW + 1)'(!busy_n[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= '0;
      avail_q <= (CW + 1)'(NCKPT);
    end else begin
      busy_q  <= busy_n;
      avail_q <= avail_n;
      if (grant) snap_q[free_id] <= map_rn;
    end
  end

  assign rs_act      = restore;
  assign rs_hit      = restore & busy_q[restore_id];
  assign restore_map = snap_q[restore_id];
  assign ckpt_grant  = grant;
  assign ckpt_id     = free_id;
  assign ckpt_avail  = avail_q;
`else
  logic unused_ckpt;

  assign unused_ckpt = ^{ckpt_req, ckpt_free_mask, restore, restore_id};
  assign rs_act      = 1'b0;
  assign rs_hit      = 1'b0;
  assign restore_map = '0;
  assign ckpt_grant  = 1'b0;
  assign ckpt_id     = '0;
  assign ckpt_avail  = '0;
`endif

endmodule
